// File: rtl/seg_scan_driver.sv
// 7-segment scan driver: shadow/active frame buffers swapped at scan wrap, dead-time
// blanking after each digit advance, flash modes. Define SEG_ACTIVE_LOW_EN for inverted outputs.
module seg_scan_driver #(
    parameter int DIGITS      = 5,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scan_tick,
    input  logic                flash_tick,
    input  logic                frame_valid,
    output logic                frame_ready,
    input  logic [8*DIGITS-1:0] frame_data,
    input  logic [1:0]          frame_mode,
    input  logic [2:0]          cursor,
    output logic [DIGITS-1:0]   dig_sel,
    output logic [7:0]          seg_pat,
    output logic                frame_swap,
    output logic                state_dbg
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef SEG_ACTIVE_LOW_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    typedef enum logic {DEAD = 1'b0, DRIVE = 1'b1} state_t;

    state_t              state_q, state_n;
    logic [IW-1:0]       dig_idx_q, dig_idx_n;
    logic [3:0]          dead_cnt_q, dead_cnt_n;
    logic                phase_q, phase_n;
    logic [8*DIGITS-1:0] sh_data_q, act_data_q, act_data_n;
    logic [1:0]          sh_mode_q, act_mode_q, act_mode_n;
    logic [2:0]          sh_cursor_q, act_cursor_q, act_cursor_n;
    logic                sh_full_q;
    logic                accept, swap, blank;
    logic [7:0]          seg_raw, seg_n;
    logic [DIGITS-1:0]   sel_n;

    // Handshake: a frame transfers on any clk with frame_valid && frame_ready; frame_ready
    // is simply "shadow empty" and never depends on frame_valid. The producer holds its frame.
    assign frame_ready = !sh_full_q;
    assign accept      = frame_valid && frame_ready;
    assign swap        = scan_tick && (dig_idx_q == IW'(DIGITS - 1)) && sh_full_q;
    assign state_dbg   = (state_q == DRIVE);

    always_comb begin
        state_n    = state_q;
        dig_idx_n  = dig_idx_q;
        dead_cnt_n = dead_cnt_q;
        if (scan_tick) begin
            state_n    = DEAD;
            dead_cnt_n = '0;
            dig_idx_n  = (dig_idx_q == IW'(DIGITS - 1)) ? '0 : dig_idx_q + IW'(1);
        end else if (state_q == DEAD) begin
            if (dead_cnt_q == 4'(DEAD_CYCLES - 1)) state_n = DRIVE;
            else dead_cnt_n = dead_cnt_q + 4'd1;
        end

        phase_n      = swap ? 1'b1 : (flash_tick ? !phase_q : phase_q);
        act_data_n   = swap ? sh_data_q   : act_data_q;
        act_mode_n   = swap ? sh_mode_q   : act_mode_q;
        act_cursor_n = swap ? sh_cursor_q : act_cursor_q;

        // Outputs are registered from post-edge state so they line up with the FSM.
        case (act_mode_n)
            2'd1:    blank = !phase_n;
            2'd2:    blank = !phase_n && (32'(act_cursor_n) == 32'(dig_idx_n));
            2'd3:    blank = 1'b1;
            default: blank = 1'b0;
        endcase

        seg_raw = '0;
        sel_n   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_idx_n == IW'(i)) begin
                seg_raw  = act_data_n[8*(DIGITS-1-i) +: 8];
                sel_n[i] = 1'b1;
            end
        end
        seg_n = (blank || state_n != DRIVE) ? 8'd0 : seg_raw;
        if (state_n != DRIVE) sel_n = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= DEAD;
            dig_idx_q    <= '0;
            dead_cnt_q   <= '0;
            phase_q      <= 1'b1;
            sh_data_q    <= '0;
            sh_mode_q    <= '0;
            sh_cursor_q  <= '0;
            sh_full_q    <= 1'b0;
            act_data_q   <= '0;
            act_mode_q   <= '0;
            act_cursor_q <= '0;
            dig_sel      <= {DIGITS{POL}};
            seg_pat      <= {8{POL}};
            frame_swap   <= 1'b0;
        end else begin
            state_q      <= state_n;
            dig_idx_q    <= dig_idx_n;
            dead_cnt_q   <= dead_cnt_n;
            phase_q      <= phase_n;
            act_data_q   <= act_data_n;
            act_mode_q   <= act_mode_n;
            act_cursor_q <= act_cursor_n;
            if (accept) begin
                sh_data_q   <= frame_data;
                sh_mode_q   <= frame_mode;
                sh_cursor_q <= cursor;
                sh_full_q   <= 1'b1;
            end else if (swap) begin
                sh_full_q <= 1'b0;
            end
            dig_sel    <= sel_n ^ {DIGITS{POL}};
            seg_pat    <= seg_n ^ {8{POL}};
            frame_swap <= swap;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scans plus random traffic against a cycle-level model.
// Build with SEG_ACTIVE_LOW_EN to check the inverted-output variant.
module tb_seg_scan_driver;
    localparam int DIGITS      = 5;
    localparam int DEAD_CYCLES = 2;
`ifdef SEG_ACTIVE_LOW_EN
    localparam bit POL = 1'b1;
`else
    localparam bit POL = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                scan_tick, flash_tick, frame_valid;
    logic                frame_ready, frame_swap, state_dbg;
    logic [8*DIGITS-1:0] frame_data;
    logic [1:0]          frame_mode;
    logic [2:0]          cursor;
    logic [DIGITS-1:0]   dig_sel;
    logic [7:0]          seg_pat;

    seg_scan_driver #(.DIGITS(DIGITS), .DEAD_CYCLES(DEAD_CYCLES)) dut (
        .clk(clk), .reset(reset), .scan_tick(scan_tick), .flash_tick(flash_tick),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
        .frame_mode(frame_mode), .cursor(cursor), .dig_sel(dig_sel), .seg_pat(seg_pat),
        .frame_swap(frame_swap), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [DIGITS-1:0] psel(input logic [DIGITS-1:0] v);
        return v ^ {DIGITS{POL}};
    endfunction
    function automatic logic [7:0] pseg(input logic [7:0] v);
        return v ^ {8{POL}};
    endfunction

    // Model: which digit is selected, clks since the last digit advance, flash phase, buffers.
    int                  m_idx, m_since;
    bit                  m_phase, m_full, m_swap, m_acc;
    logic [8*DIGITS-1:0] m_act_data, m_sh_data;
    int                  m_act_mode, m_sh_mode, m_act_cur, m_sh_cur;

    task automatic model_reset();
        m_idx = 0; m_since = 0; m_phase = 1; m_full = 0; m_swap = 0; m_acc = 0;
        m_act_data = '0; m_sh_data = '0; m_act_mode = 0; m_sh_mode = 0;
        m_act_cur = 0; m_sh_cur = 0;
    endtask

    always @(posedge clk) begin : mdl
        bit acc, sw;
        if (reset) begin
            acc = frame_valid && !m_full;
            sw  = scan_tick && (m_idx == DIGITS - 1) && m_full;
            if (scan_tick) begin
                m_idx   = (m_idx + 1) % DIGITS;
                m_since = 0;
            end else if (m_since < 1000) begin
                m_since++;
            end
            if (sw) begin
                m_act_data = m_sh_data; m_act_mode = m_sh_mode; m_act_cur = m_sh_cur;
                m_full = 0; m_phase = 1;
            end else if (flash_tick) begin
                m_phase = !m_phase;
            end
            if (acc) begin
                m_sh_data = frame_data; m_sh_mode = int'(frame_mode); m_sh_cur = int'(cursor);
                m_full = 1;
            end
            m_swap = sw;
            m_acc  = acc;
        end
    end

    always @(negedge clk) begin : cmp
        bit vis, blk;
        logic [7:0] e_seg;
        logic [DIGITS-1:0] e_sel;
        if (reset) begin
            vis   = (m_since >= DEAD_CYCLES);
            blk   = (m_act_mode == 3) || (m_act_mode == 1 && !m_phase) ||
                    (m_act_mode == 2 && !m_phase && m_act_cur == m_idx);
            e_sel = vis ? (DIGITS'(1) << m_idx) : '0;
            e_seg = (vis && !blk) ? 8'(m_act_data >> (8 * (DIGITS - 1 - m_idx))) : 8'd0;
            check("dig_sel", dig_sel, psel(e_sel));
            check("seg_pat", seg_pat, pseg(e_seg));
            check("frame_ready", frame_ready, !m_full);
            check("frame_swap", frame_swap, m_swap);
            check("state_dbg", state_dbg, vis);
        end
    end

    task automatic drive(input bit st, input bit ft, input bit fv);
        scan_tick = st; flash_tick = ft; frame_valid = fv;
        @(negedge clk);
        scan_tick = 0; flash_tick = 0;
    endtask

    task automatic run(input int n, input int tp, input int fp);
        for (int c = 0; c < n; c++) begin
            scan_tick  = (tp > 0) && (c % tp == tp - 1);
            flash_tick = (fp > 0) && (c % fp == fp - 1);
            @(negedge clk);
            if (m_acc) frame_valid = 0;
        end
        scan_tick = 0; flash_tick = 0;
    endtask

    task automatic offer(input logic [8*DIGITS-1:0] d, input logic [1:0] md, input logic [2:0] cur);
        frame_data = d; frame_mode = md; cursor = cur; frame_valid = 1;
    endtask

    logic [7:0] f1 [DIGITS] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66};
    localparam logic [8*DIGITS-1:0] FRAME1 = 40'h3F_06_5B_4F_66;
    localparam logic [8*DIGITS-1:0] FRAME2 = 40'h7D_07_7F_6F_77;

    initial begin
        bit reached;
        reset = 0; scan_tick = 0; flash_tick = 0; frame_valid = 0;
        frame_data = '0; frame_mode = 0; cursor = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_dig_sel", dig_sel, psel('0));
        check("rst_seg_pat", seg_pat, pseg(8'd0));
        check("rst_ready", frame_ready, 1'b1);
        check("rst_swap", frame_swap, 1'b0);
        reset = 1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        check("boot_digit0", dig_sel, psel(5'b00001));
        check("boot_dark", seg_pat, pseg(8'd0));

        // Asynchronous reset while driving digit 2.
        drive(1, 0, 0); drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
        check("pre_rst_sel", dig_sel, psel(5'b00100));
        #2 reset = 0;
        model_reset();
        #1;
        check("async_rst_sel", dig_sel, psel('0));
        check("async_rst_seg", seg_pat, pseg(8'd0));
        check("async_rst_ready", frame_ready, 1'b1);
        @(negedge clk);
        reset = 1;
        drive(0, 0, 0); drive(0, 0, 0);
        check("post_rst_sel", dig_sel, psel(5'b00001));

        // Frame load, shadow-full hold-off, swap at wrap, then one scan through the digits.
        offer(FRAME1, 2'd0, 3'd0);
        drive(0, 0, 1);
        check("accept_ready_low", frame_ready, 1'b0);
        offer(FRAME2, 2'd0, 3'd0);
        for (int k = 0; k < DIGITS - 1; k++) begin
            drive(1, 0, 1);
            repeat (3) drive(0, 0, 1);
        end
        check("held_ready_low", frame_ready, 1'b0);
        drive(1, 0, 1);
        check("swap_pulse", frame_swap, 1'b1);
        check("swap_ready_high", frame_ready, 1'b1);
        check("swap_dead", dig_sel, psel('0));
        drive(0, 0, 1);
        check("second_accept", frame_ready, 1'b0);
        check("swap_one_clk", frame_swap, 1'b0);
        drive(0, 0, 0);
        check("digit0_sel", dig_sel, psel(5'b00001));
        check("digit0_seg", seg_pat, pseg(f1[0]));
        for (int d = 1; d < DIGITS; d++) begin
            drive(1, 0, 0);
            check("dead1", dig_sel, psel('0));
            drive(0, 0, 0);
            check("dead2", dig_sel, psel('0));
            drive(0, 0, 0);
            check("digit_sel", dig_sel, psel(DIGITS'(1) << d));
            check("digit_seg", seg_pat, pseg(f1[d]));
        end

        // Flash all, flash cursor 3, cursor out of range.
        offer(FRAME1, 2'd1, 3'd0);
        run(80, 6, 0);
        run(400, 6, 100);
        offer(FRAME2, 2'd2, 3'd3);
        run(80, 6, 0);
        run(300, 6, 50);
        offer(FRAME1, 2'd2, 3'd6);
        run(80, 6, 0);
        run(300, 6, 50);

        // flash_tick coincident with a swap: swap wins, frame starts visible.
        offer(FRAME1, 2'd1, 3'd0);
        reached = 0;
        for (int c = 0; c < 200 && !reached; c++) begin
            if (m_full && m_idx == DIGITS - 1 && m_since > DEAD_CYCLES) begin
                if (!m_phase) drive(0, 1, 0);
                drive(1, 1, 0);
                reached = 1;
            end else begin
                drive(c % 6 == 5, 0, frame_valid && !m_acc);
                if (m_acc) frame_valid = 0;
            end
        end
        check("coincident_reached", reached, 1'b1);
        check("coincident_swap", frame_swap, 1'b1);
        drive(0, 0, 0); drive(0, 0, 0);
        check("coincident_visible", seg_pat, pseg(8'h3F));

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if (!frame_valid && $urandom_range(0, 9) == 0)
                offer(40'({$urandom(), $urandom()}), 2'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)));
            scan_tick  = ($urandom_range(0, 4) == 0);
            flash_tick = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            if (m_acc) frame_valid = 0;
        end
        scan_tick = 0; flash_tick = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
